// File: rtl/mmu_table_walker_pkg.sv
// Shared widths, state/fault encodings and PTE address helpers for the
// two-level page-table walker.
package mmu_table_walker_pkg;

  localparam int VA_TAG_W = 18;
  localparam int TID_W    = 14;
  localparam int FLAGS_W  = 14;
  localparam int PPN_W    = 18;
  localparam int PTBR_W   = 22;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_L1_REQ  = 3'd1,
    ST_L1_WAIT = 3'd2,
    ST_L2_REQ  = 3'd3,
    ST_L2_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } walk_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'd0,
    FAULT_L1      = 2'd1,
    FAULT_L2      = 2'd2,
    FAULT_TIMEOUT = 2'd3
  } fault_e;

  function automatic logic [31:0] l1_pte_addr(input logic [PTBR_W-1:0] base,
                                              input logic [7:0] l1_idx);
    return {base, l1_idx, 2'b00};
  endfunction

  function automatic logic [31:0] l2_pte_addr(input logic [19:0] base,
                                              input logic [9:0] l2_idx);
    return {base, l2_idx, 2'b00};
  endfunction

endpackage

// File: rtl/mmu_table_walker_if.sv
// Miss request, memory read port, TLB fill port and completion signals of the
// walker; master = walker side, slave = requester/memory/TLB side.
interface mmu_table_walker_if;
  import mmu_table_walker_pkg::*;

  logic                iREMOVE;
  logic                iREQ_VALID;
  logic                oREQ_BUSY;
  logic [VA_TAG_W-1:0] iREQ_ADDR;
  logic [TID_W-1:0]    iREQ_TID;
  logic [31:0]         iPTBR;
  logic                oMEM_REQ;
  logic                iMEM_BUSY;
  logic [31:0]         oMEM_ADDR;
  logic                iMEM_VALID;
  logic [31:0]         iMEM_DATA;
  logic                oTLB_WR_REQ;
  logic [VA_TAG_W-1:0] oTLB_WR_ADDR;
  logic [TID_W-1:0]    oTLB_WR_TID;
  logic [FLAGS_W-1:0]  oTLB_WR_FLAGS;
  logic [PPN_W-1:0]    oTLB_WR_PHYS_ADDR;
  logic                oDONE_VALID;
  logic                oDONE_FAULT;
  logic [1:0]          oDONE_FAULT_LEVEL;
  logic [FLAGS_W-1:0]  oDONE_FLAGS;
  logic [PPN_W-1:0]    oDONE_PHYS_ADDR;

  modport master (
    input  iREMOVE, iREQ_VALID, iREQ_ADDR, iREQ_TID, iPTBR,
           iMEM_BUSY, iMEM_VALID, iMEM_DATA,
    output oREQ_BUSY, oMEM_REQ, oMEM_ADDR,
           oTLB_WR_REQ, oTLB_WR_ADDR, oTLB_WR_TID, oTLB_WR_FLAGS, oTLB_WR_PHYS_ADDR,
           oDONE_VALID, oDONE_FAULT, oDONE_FAULT_LEVEL, oDONE_FLAGS, oDONE_PHYS_ADDR
  );

  modport slave (
    output iREMOVE, iREQ_VALID, iREQ_ADDR, iREQ_TID, iPTBR,
           iMEM_BUSY, iMEM_VALID, iMEM_DATA,
    input  oREQ_BUSY, oMEM_REQ, oMEM_ADDR,
           oTLB_WR_REQ, oTLB_WR_ADDR, oTLB_WR_TID, oTLB_WR_FLAGS, oTLB_WR_PHYS_ADDR,
           oDONE_VALID, oDONE_FAULT, oDONE_FAULT_LEVEL, oDONE_FLAGS, oDONE_PHYS_ADDR
  );

endinterface

// File: rtl/mmu_table_walker_watchdog.sv
// Memory-response watchdog: saturating up-counter, expired at all-ones.
module mmu_table_walker_watchdog #(
  parameter int TIMEOUT_N = 8
) (
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TIMEOUT_N-1:0] count_q;

  assign expired_o = &count_q;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)                 count_q <= '0;
    else if (clr_i)               count_q <= '0;
    else if (en_i && !expired_o)  count_q <= count_q + 1'b1;
  end

endmodule

// File: rtl/mmu_table_walker.sv
// Two-level hardware page-table walker: refills the TLB on a miss and reports
// the translation or a fault to the requester.
//  state   | meaning
//  IDLE    | waiting for a miss (busy while a dropped response is pending)
//  L1_REQ  | L1 PTE read presented to memory
//  L1_WAIT | waiting for the L1 PTE
//  L2_REQ  | L2 PTE read presented to memory
//  L2_WAIT | waiting for the L2 PTE
//  DONE    | one cycle: launch done pulse / TLB fill
module mmu_table_walker
  import mmu_table_walker_pkg::*;
#(
  parameter int TIMEOUT_N     = 8,
  parameter int PTE_VALID_BIT = 0
) (
  input logic               iCLOCK,
  input logic               inRESET,
  mmu_table_walker_if.master bus
);

  walk_state_e         state_q, state_d;
  fault_e              fault_q, fault_d;
  logic                drop_q, drop_d;
  logic [VA_TAG_W-1:0] tag_q, tag_d;
  logic [TID_W-1:0]    tid_q, tid_d;
  logic [31:0]         pte_q, pte_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;

  logic                done_valid_q, done_fault_q, tlb_wr_q;
  logic [1:0]          done_level_q;
  logic [FLAGS_W-1:0]  done_flags_q;
  logic [PPN_W-1:0]    done_phys_q;
  logic [VA_TAG_W-1:0] tlb_addr_q;
  logic [TID_W-1:0]    tlb_tid_q;

  logic in_wait, in_req, next_wait, wd_clr, wd_en, wd_expired;
  logic done_fire, success;

  assign in_wait   = (state_q == ST_L1_WAIT) || (state_q == ST_L2_WAIT);
  assign in_req    = (state_q == ST_L1_REQ)  || (state_q == ST_L2_REQ);
  assign next_wait = (state_d == ST_L1_WAIT) || (state_d == ST_L2_WAIT);
  assign wd_clr    = (in_req && next_wait) || (drop_d && !drop_q);
  assign wd_en     = (in_wait || drop_q) && !bus.iMEM_VALID;

  mmu_table_walker_watchdog #(.TIMEOUT_N(TIMEOUT_N)) u_watchdog (
    .iCLOCK    (iCLOCK),
    .inRESET   (inRESET),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    drop_d     = drop_q;
    tag_d      = tag_q;
    tid_d      = tid_q;
    pte_d      = pte_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;

    // The drop flag only ever lives outside the WAIT states.
    if (drop_q && (bus.iMEM_VALID || wd_expired)) drop_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.iREQ_VALID && !drop_q) begin
          tag_d      = bus.iREQ_ADDR;
          tid_d      = bus.iREQ_TID;
          fault_d    = FAULT_NONE;
          mem_req_d  = 1'b1;
          mem_addr_d = l1_pte_addr(bus.iPTBR[31:10], bus.iREQ_ADDR[17:10]);
          state_d    = ST_L1_REQ;
        end
      end
      ST_L1_REQ, ST_L2_REQ: begin
        if (!bus.iMEM_BUSY) begin
          mem_req_d = 1'b0;
          state_d   = (state_q == ST_L1_REQ) ? ST_L1_WAIT : ST_L2_WAIT;
        end
      end
      ST_L1_WAIT: begin
        if (bus.iMEM_VALID) begin
          if (!bus.iMEM_DATA[PTE_VALID_BIT]) begin
            fault_d = FAULT_L1;
            state_d = ST_DONE;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = l2_pte_addr(bus.iMEM_DATA[31:12], tag_q[9:0]);
            state_d    = ST_L2_REQ;
          end
        end else if (wd_expired) begin
          fault_d = FAULT_TIMEOUT;
          drop_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_L2_WAIT: begin
        if (bus.iMEM_VALID) begin
          pte_d   = bus.iMEM_DATA;
          fault_d = bus.iMEM_DATA[PTE_VALID_BIT] ? FAULT_NONE : FAULT_L2;
          state_d = ST_DONE;
        end else if (wd_expired) begin
          fault_d = FAULT_TIMEOUT;
          drop_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A read already accepted by memory will still answer; remember to swallow it.
    if (bus.iREMOVE) begin
      state_d    = ST_IDLE;
      mem_req_d  = 1'b0;
      mem_addr_d = '0;
      if (in_wait || (in_req && !bus.iMEM_BUSY)) drop_d = 1'b1;
    end
  end

  assign done_fire = (state_q == ST_DONE) && !bus.iREMOVE;
  assign success   = done_fire && (fault_q == FAULT_NONE);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q      <= ST_IDLE;
      fault_q      <= FAULT_NONE;
      drop_q       <= 1'b0;
      tag_q        <= '0;
      tid_q        <= '0;
      pte_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      done_valid_q <= 1'b0;
      done_fault_q <= 1'b0;
      done_level_q <= '0;
      done_flags_q <= '0;
      done_phys_q  <= '0;
      tlb_wr_q     <= 1'b0;
      tlb_addr_q   <= '0;
      tlb_tid_q    <= '0;
    end else begin
      state_q      <= state_d;
      fault_q      <= fault_d;
      drop_q       <= drop_d;
      tag_q        <= tag_d;
      tid_q        <= tid_d;
      pte_q        <= pte_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      done_valid_q <= done_fire;
      done_fault_q <= done_fire && (fault_q != FAULT_NONE);
      done_level_q <= done_fire ? fault_q : 2'd0;
      done_flags_q <= success ? pte_q[FLAGS_W-1:0] : '0;
      done_phys_q  <= success ? pte_q[31:32-PPN_W] : '0;
      tlb_wr_q     <= success;
      tlb_addr_q   <= success ? tag_q : '0;
      tlb_tid_q    <= success ? tid_q : '0;
    end
  end

  assign bus.oREQ_BUSY         = (state_q != ST_IDLE) || drop_q;
  assign bus.oMEM_REQ          = mem_req_q;
  assign bus.oMEM_ADDR         = mem_addr_q;
  assign bus.oTLB_WR_REQ       = tlb_wr_q;
  assign bus.oTLB_WR_ADDR      = tlb_addr_q;
  assign bus.oTLB_WR_TID       = tlb_tid_q;
  assign bus.oTLB_WR_FLAGS     = done_flags_q;
  assign bus.oTLB_WR_PHYS_ADDR = done_phys_q;
  assign bus.oDONE_VALID       = done_valid_q;
  assign bus.oDONE_FAULT       = done_fault_q;
  assign bus.oDONE_FAULT_LEVEL = done_level_q;
  assign bus.oDONE_FLAGS       = done_flags_q;
  assign bus.oDONE_PHYS_ADDR   = done_phys_q;

endmodule
